// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes the payload into RAM and
// releases the processor once the image checksum verifies.
module prog_loader #(
    parameter int unsigned          ADDR_W = 15,
    parameter int unsigned          DATA_W = 8,
    parameter logic [DATA_W-1:0]    SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              busy,
    output logic              cpu_run,
    output logic              load_err
);

    localparam int unsigned WordW  = 2 * DATA_W;
    // Largest payload that fits in the address space without overlapping itself.
    localparam logic [32:0] MaxLen = 33'(1) << ADDR_W;

    typedef enum logic [3:0] {
        StIdle,
        StAddrH,
        StAddrL,
        StLenH,
        StLenL,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;        // shared holding byte for ADDR_H and LEN_H
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WordW-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic [WordW-1:0]  word;

    assign word = {hi_q, in_data};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // Frame parser: advances one field per accepted byte.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        count_d    = count_q;
        sum_d      = sum_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        if (in_valid) begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (in_data == SYNC) begin
                        state_d = StAddrH;
                        sum_d   = '0;
                        count_d = '0;
                    end
                end
                StAddrH: begin
                    hi_d    = in_data;
                    state_d = StAddrL;
                end
                StAddrL: begin
                    addr_d  = word[ADDR_W-1:0];
                    state_d = StLenH;
                end
                StLenH: begin
                    hi_d    = in_data;
                    state_d = StLenL;
                end
                StLenL: begin
                    if (33'(word) > MaxLen) begin
                        state_d = StError;
                    end else if (word == '0) begin
                        state_d = StCsum;
                    end else begin
                        count_d = word;
                        state_d = StData;
                    end
                end
                StData: begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = in_data;
                    addr_d     = addr_q + 1'b1;
                    sum_d      = sum_q + in_data;
                    count_d    = count_q - 1'b1;
                    if (count_q == WordW'(1)) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    state_d = (in_data == sum_q) ? StDone : StError;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs: the write port is registered, status flags decode directly from the state.
    always_comb begin
        in_ready = 1'b1;
        ram_addr = ram_addr_q;
        ram_din  = ram_din_q;
        ram_we   = ram_we_q;
        cpu_run  = (state_q == StDone);
        load_err = (state_q == StError);
        busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a frame-level model predicts every output on every
// cycle, plus literal checks of the directed scenarios.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        busy;
    logic        cpu_run;
    logic        load_err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .busy     (busy),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    // Expected outputs for the cycle after the most recent clock edge.
    logic        exp_we = 1'b0;
    logic        exp_run = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_busy = 1'b0;
    logic [14:0] exp_addr = '0;
    logic [7:0]  exp_din = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int gap_pct  = 0;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t        wlog[$];
    logic [7:0] fixed_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", 32'(in_ready), 32'd1);
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
            chk("ram_din", 32'(ram_din), 32'(exp_din));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("cpu_run", 32'(cpu_run), 32'(exp_run));
            chk("load_err", 32'(load_err), 32'(exp_err));
            if (ram_we === 1'b1) wlog.push_back('{ram_addr, ram_din});
        end
    end

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        exp_we   = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] d);
        for (int g = 0; g < 3; g++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1'b0, 1'b0, 8'($urandom));
        end
        step(1'b0, 1'b1, d);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00);
        exp_we   = 1'b0;
        exp_run  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
        check_en = 1'b1;
    endtask

    task automatic garbage();
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        xfer(g);
    endtask

    // Sends one frame; abort_at >= 0 resets the loader before that payload byte.
    task automatic send_frame(input logic [15:0] start, input logic [15:0] len,
                              input bit bad_csum, input int abort_at);
        logic [7:0]  sum;
        logic [7:0]  b;
        int unsigned a;
        sum = 8'h00;
        xfer(8'hA5);
        exp_busy = 1'b1;
        exp_run  = 1'b0;
        exp_err  = 1'b0;
        xfer(start[15:8]);
        xfer(start[7:0]);
        xfer(len[15:8]);
        xfer(len[7:0]);
        if (len > 16'h8000) begin
            exp_busy = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if (fixed_q.size() > 0) b = fixed_q.pop_front();
            else b = 8'($urandom);
            xfer(b);
            a        = (int'(start) + i) % 32768;
            exp_we   = 1'b1;
            exp_addr = a[14:0];
            exp_din  = b;
            sum      = sum + b;
        end
        xfer(bad_csum ? sum + 8'd1 : sum);
        exp_busy = 1'b0;
        exp_run  = !bad_csum;
        exp_err  = bad_csum;
    endtask

    initial begin
        do_reset();
        step(1'b0, 1'b0, 8'h00);

        // 1: basic load, literal writes
        wlog.delete();
        fixed_q = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 16'd3, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t1_nwr", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("t1_a0", 32'(wlog[0].a), 32'h0010);
            chk("t1_d0", 32'(wlog[0].d), 32'h11);
            chk("t1_a2", 32'(wlog[2].a), 32'h0012);
            chk("t1_d2", 32'(wlog[2].d), 32'h33);
        end
        chk("t1_run", 32'(cpu_run), 32'd1);

        // 2: bad checksum, then an empty image
        wlog.delete();
        fixed_q = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 16'd3, 1'b1, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t2_nwr", 32'(wlog.size()), 32'd3);
        chk("t2_err", 32'(load_err), 32'd1);
        chk("t2_run", 32'(cpu_run), 32'd0);
        send_frame(16'h0000, 16'd0, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t2_err_clr", 32'(load_err), 32'd0);
        chk("t2_run2", 32'(cpu_run), 32'd1);

        // 3: garbage then a wrapping frame with gaps
        do_reset();
        xfer(8'h00);
        xfer(8'hFF);
        xfer(8'h12);
        wlog.delete();
        gap_pct = 40;
        fixed_q = '{8'hAA, 8'hBB};
        send_frame(16'h7FFF, 16'd2, 1'b0, -1);
        gap_pct = 0;
        step(1'b0, 1'b0, 8'h00);
        chk("t3_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("t3_a0", 32'(wlog[0].a), 32'h7FFF);
            chk("t3_d0", 32'(wlog[0].d), 32'hAA);
            chk("t3_a1", 32'(wlog[1].a), 32'h0000);
            chk("t3_d1", 32'(wlog[1].d), 32'hBB);
        end
        chk("t3_run", 32'(cpu_run), 32'd1);

        // 4: oversize length
        wlog.delete();
        send_frame(16'h0000, 16'h8001, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t4_err", 32'(load_err), 32'd1);
        chk("t4_nwr", 32'(wlog.size()), 32'd0);

        // 5: reset mid-payload, then a good frame
        send_frame(16'h0100, 16'd3, 1'b0, 1);
        step(1'b0, 1'b0, 8'h00);
        chk("t5_addr", 32'(ram_addr), 32'd0);
        send_frame(16'h0200, 16'd5, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t5_run", 32'(cpu_run), 32'd1);

        // 6: reload from DONE
        send_frame(16'h1234, 16'd4, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("t6_run", 32'(cpu_run), 32'd1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            logic [15:0] st;
            logic [15:0] ln;
            st      = 16'($urandom);
            ln      = 16'($urandom_range(40));
            gap_pct = int'($urandom_range(50));
            if ($urandom_range(9) == 0) ln = 16'($urandom_range(16'hFFFF, 16'h8001));
            if ($urandom_range(3) == 0) garbage();
            if ($urandom_range(9) == 0) send_frame(st, 16'd6, 1'b0, int'($urandom_range(5)));
            else send_frame(st, ln, ($urandom_range(4) == 0), -1);
            if ($urandom_range(2) == 0) garbage();
        end
        gap_pct = 0;

        // Largest legal image fills the whole address space
        wlog.delete();
        send_frame(16'h4321, 16'h8000, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("max_nwr", 32'(wlog.size()), 32'h8000);
        chk("max_run", 32'(cpu_run), 32'd1);

        step(1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
